// File: rtl/riscv_fetch.sv
// Instruction-fetch stage: owns the PC, issues single-cycle-latency reads and
// hands {pc, instruction} to decode through a small fall-through FIFO.
module riscv_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        fetch_en_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] iaddr_o,
    output logic        ird_o,
    input  logic [31:0] irdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    input  logic        inst_ready_i
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [31:0]    pc;
    logic [31:0]    req_pc;
    logic           inflight;
    logic           kill;
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic [CW-1:0]  count;
    logic [31:0]    fifo_pc   [DEPTH];
    logic [31:0]    fifo_inst [DEPTH];

    logic           empty;
    logic           resp;
    logic           pop;
    logic           pop_fifo;
    logic           push;
    logic           issue;
    logic           flush;
    logic [CW:0]    occ;

    // Next state and fetch issue; issue is held back whenever the FIFO plus
    // the outstanding response would exceed DEPTH after this cycle's pop.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        occ        = (CW+1)'(count) + (CW+1)'(inflight) - (CW+1)'(pop);
        unique case (state)
            IDLE:    state_next = RUN;
            RUN: begin
                if (redirect_i) begin
                    state_next = FLUSH;
                end
                issue = fetch_en_i & ~redirect_i & (occ < (CW+1)'(DEPTH));
            end
            FLUSH:   state_next = redirect_i ? FLUSH : RUN;
            default: state_next = IDLE;
        endcase
    end

    // Head of queue; an arriving response falls straight through when empty.
    always_comb begin
        empty        = (count == '0);
        resp         = inflight & ~kill;
        inst_valid_o = ~empty | resp;
        inst_o       = 32'h0;
        inst_pc_o    = 32'h0;
        if (!empty) begin
            inst_o    = fifo_inst[rd_ptr];
            inst_pc_o = fifo_pc[rd_ptr];
        end else if (resp) begin
            inst_o    = irdata_i;
            inst_pc_o = req_pc;
        end
        pop      = inst_valid_o & inst_ready_i;
        pop_fifo = pop & ~empty;
        push     = resp & ~(empty & pop);
        flush    = redirect_i & (state != IDLE);
        ird_o    = issue;
        iaddr_o  = pc;
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            pc       <= RESET_PC;
            req_pc   <= 32'h0;
            inflight <= 1'b0;
            kill     <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            inflight <= issue;
            kill     <= flush;
            if (issue) begin
                pc     <= pc + 32'd4;
                req_pc <= pc;
            end
            if (redirect_i) begin
                pc <= redirect_pc_i & 32'hFFFF_FFFC;
            end
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop_fifo) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                count <= count + CW'(push) - CW'(pop_fifo);
            end
        end
    end

    // Payload storage needs no reset; occupancy is tracked by count.
    always_ff @(posedge clk_i) begin
        if (push && !flush) begin
            fifo_pc[wr_ptr]   <= req_pc;
            fifo_inst[wr_ptr] <= irdata_i;
        end
    end

endmodule

// File: tb/tb_riscv_fetch.sv
// Bench for riscv_fetch: vector table for the main stream, scoreboard of
// issued fetches, and hand sequences for reset, wrap and idle redirect.
module tb_riscv_fetch;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned NVEC  = 24;

    logic        clk_i;
    logic        reset_i;
    logic        fetch_en_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] iaddr_o;
    logic        ird_o;
    logic [31:0] irdata_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_ready_i;

    logic        w_en;
    logic        w_redir;
    logic [31:0] w_rpc;
    logic [31:0] w_iaddr;
    logic        w_ird;
    logic [31:0] w_irdata;
    logic        w_valid;
    logic [31:0] w_inst;
    logic [31:0] w_inst_pc;
    logic        w_ready;

    int n_checks = 0;
    int n_fail   = 0;

    riscv_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .fetch_en_i   (fetch_en_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .iaddr_o      (iaddr_o),
        .ird_o        (ird_o),
        .irdata_i     (irdata_i),
        .inst_valid_o (inst_valid_o),
        .inst_o       (inst_o),
        .inst_pc_o    (inst_pc_o),
        .inst_ready_i (inst_ready_i)
    );

    riscv_fetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) dut_wrap (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .fetch_en_i   (w_en),
        .redirect_i   (w_redir),
        .redirect_pc_i(w_rpc),
        .iaddr_o      (w_iaddr),
        .ird_o        (w_ird),
        .irdata_i     (w_irdata),
        .inst_valid_o (w_valid),
        .inst_o       (w_inst),
        .inst_pc_o    (w_inst_pc),
        .inst_ready_i (w_ready)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory with one cycle of read latency for both instances.
    logic [31:0] rd_next;
    logic [31:0] w_rd_next;
    always @(negedge clk_i) begin
        rd_next   = ird_o ? mem_word(iaddr_o) : 32'hBAD0_BAD0;
        w_rd_next = w_ird ? mem_word(w_iaddr) : 32'hBAD0_BAD0;
    end
    always @(posedge clk_i) begin
        #1;
        irdata_i = rd_next;
        w_irdata = w_rd_next;
    end

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;
    exp_t sb_q[$];

    // Scoreboard: issues enqueue, handshakes pop in order, redirect discards.
    always @(negedge clk_i) begin
        exp_t e;
        if (!reset_i) begin
            sb_q.delete();
        end else begin
            if (inst_valid_o && inst_ready_i) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_pop", 32'(inst_pc_o), 32'hFFFF_FFFF);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_pc", inst_pc_o, e.pc);
                    check("sb_inst", inst_o, e.inst);
                end
            end
            if (redirect_i) sb_q.delete();
            if (ird_o) sb_q.push_back({iaddr_o, mem_word(iaddr_o)});
            check("sb_occupancy_le_depth", 32'(sb_q.size() <= DEPTH), 32'd1);
        end
    end

    typedef struct packed {
        logic        en;
        logic        rdy;
        logic        redir;
        logic [31:0] rpc;
        logic        ird;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
    } vec_t;

    function automatic vec_t v(input logic en, input logic rdy, input logic redir,
                               input logic [31:0] rpc, input logic ird,
                               input logic [31:0] addr, input logic valid,
                               input logic [31:0] pc);
        return '{en, rdy, redir, rpc, ird, addr, valid, pc};
    endfunction

    task automatic drive(input logic en, input logic rdy, input logic redir, input logic [31:0] rpc);
        fetch_en_i    = en;
        inst_ready_i  = rdy;
        redirect_i    = redir;
        redirect_pc_i = rpc;
    endtask

    task automatic check_main(input string tag, input logic ird, input logic [31:0] addr,
                              input logic valid, input logic [31:0] pc);
        check({tag, "_ird"},   32'(ird_o), 32'(ird));
        check({tag, "_iaddr"}, iaddr_o, addr);
        check({tag, "_valid"}, 32'(inst_valid_o), 32'(valid));
        check({tag, "_pc"},    inst_pc_o, valid ? pc : 32'h0);
        check({tag, "_inst"},  inst_o, valid ? mem_word(pc) : 32'h0);
    endtask

    vec_t vt[NVEC];

    initial begin
        vt[0]  = v(1, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0);
        vt[1]  = v(1, 0, 0, 32'h0,   1, 32'h0,   0, 32'h0);
        vt[2]  = v(1, 0, 0, 32'h0,   1, 32'h4,   1, 32'h0);
        vt[3]  = v(1, 0, 0, 32'h0,   0, 32'h8,   1, 32'h0);
        vt[4]  = v(1, 0, 0, 32'h0,   0, 32'h8,   1, 32'h0);
        vt[5]  = v(1, 0, 0, 32'h0,   0, 32'h8,   1, 32'h0);
        vt[6]  = v(1, 1, 0, 32'h0,   1, 32'h8,   1, 32'h0);
        vt[7]  = v(1, 1, 0, 32'h0,   1, 32'hC,   1, 32'h4);
        vt[8]  = v(1, 1, 0, 32'h0,   1, 32'h10,  1, 32'h8);
        vt[9]  = v(1, 1, 0, 32'h0,   1, 32'h14,  1, 32'hC);
        vt[10] = v(0, 1, 0, 32'h0,   0, 32'h18,  1, 32'h10);
        vt[11] = v(0, 1, 0, 32'h0,   0, 32'h18,  1, 32'h14);
        vt[12] = v(0, 1, 0, 32'h0,   0, 32'h18,  0, 32'h0);
        vt[13] = v(1, 1, 0, 32'h0,   1, 32'h18,  0, 32'h0);
        vt[14] = v(1, 1, 0, 32'h0,   1, 32'h1C,  1, 32'h18);
        vt[15] = v(1, 0, 1, 32'h13,  0, 32'h20,  1, 32'h1C);
        vt[16] = v(1, 1, 0, 32'h0,   0, 32'h10,  0, 32'h0);
        vt[17] = v(1, 1, 0, 32'h0,   1, 32'h10,  0, 32'h0);
        vt[18] = v(1, 1, 0, 32'h0,   1, 32'h14,  1, 32'h10);
        vt[19] = v(1, 1, 1, 32'h100, 0, 32'h18,  1, 32'h14);
        vt[20] = v(1, 1, 1, 32'h203, 0, 32'h100, 0, 32'h0);
        vt[21] = v(1, 1, 0, 32'h0,   0, 32'h200, 0, 32'h0);
        vt[22] = v(1, 1, 0, 32'h0,   1, 32'h200, 0, 32'h0);
        vt[23] = v(1, 1, 0, 32'h0,   1, 32'h204, 1, 32'h200);

        w_en = 1'b1; w_redir = 1'b0; w_rpc = 32'h0; w_ready = 1'b1;
        irdata_i = 32'h0; w_irdata = 32'h0;
        reset_i = 1'b0;
        drive(0, 0, 0, 32'h0);
        #1;
        check_main("reset", 0, 32'h0, 0, 32'h0);
        repeat (3) @(posedge clk_i);

        // Main stream: startup, back-pressure, fetch disable, redirects.
        #1;
        reset_i = 1'b1;
        drive(vt[0].en, vt[0].rdy, vt[0].redir, vt[0].rpc);
        for (int i = 0; i < NVEC; i++) begin
            if (i > 0) begin
                @(posedge clk_i); #1;
                drive(vt[i].en, vt[i].rdy, vt[i].redir, vt[i].rpc);
            end
            @(negedge clk_i);
            check_main($sformatf("vec%0d", i), vt[i].ird, vt[i].addr, vt[i].valid, vt[i].pc);
        end

        // Fill the FIFO, then assert reset between clock edges.
        @(posedge clk_i); #1; drive(1, 0, 0, 32'h0);
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("full_head_pc", inst_pc_o, 32'h204);
        check("full_ird", 32'(ird_o), 32'h0);
        @(posedge clk_i); #3;
        reset_i = 1'b0;
        #1;
        check_main("async_reset", 0, 32'h0, 0, 32'h0);
        check("async_reset_wrap_iaddr", w_iaddr, 32'hFFFF_FFF8);

        // Release: first fetch at reset PC; wrap instance crosses 2^32.
        @(posedge clk_i); #1;
        reset_i = 1'b1;
        drive(1, 1, 0, 32'h0);
        @(negedge clk_i);
        check_main("rel_idle", 0, 32'h0, 0, 32'h0);
        check("wrap_idle_ird", 32'(w_ird), 32'h0);
        check("wrap_idle_iaddr", w_iaddr, 32'hFFFF_FFF8);
        @(negedge clk_i);
        check_main("rel_first", 1, 32'h0, 0, 32'h0);
        check("wrap_c1_iaddr", w_iaddr, 32'hFFFF_FFF8);
        @(negedge clk_i);
        check("wrap_c2_iaddr", w_iaddr, 32'hFFFF_FFFC);
        check("wrap_c2_pc", w_inst_pc, 32'hFFFF_FFF8);
        check("wrap_c2_inst", w_inst, mem_word(32'hFFFF_FFF8));
        @(negedge clk_i);
        check("wrap_c3_iaddr", w_iaddr, 32'h0000_0000);
        check("wrap_c3_pc", w_inst_pc, 32'hFFFF_FFFC);
        @(negedge clk_i);
        check("wrap_c4_pc", w_inst_pc, 32'h0000_0000);
        check("wrap_c4_inst", w_inst, mem_word(32'h0));

        // Redirect while IDLE only loads the PC; fetch starts there normally.
        @(posedge clk_i); #3;
        reset_i = 1'b0;
        @(posedge clk_i); #1;
        reset_i = 1'b1;
        drive(1, 1, 1, 32'h0000_0042);
        @(negedge clk_i);
        check_main("idle_redir", 0, 32'h0, 0, 32'h0);
        @(posedge clk_i); #1; drive(1, 1, 0, 32'h0);
        @(negedge clk_i);
        check_main("idle_redir_run", 1, 32'h40, 0, 32'h0);
        @(negedge clk_i);
        check_main("idle_redir_data", 1, 32'h44, 1, 32'h40);

        // Drain everything and confirm nothing expected is left behind.
        @(posedge clk_i); #1; drive(0, 1, 0, 32'h0);
        repeat (4) @(negedge clk_i);
        check("drain_valid", 32'(inst_valid_o), 32'h0);
        check("drain_sb_empty", 32'(sb_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
